vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised VGA/LCD timing and test-pattern generator, the next generation of our fixed 480x272 bouncing-square generator. It produces sync, data-enable and 24-bit RGB for any panel geometry and sync polarity. It offers four run-time selectable patterns with glitch-free mode switching at frame boundaries, and exports pixel coordinates and frame/line strobes for downstream overlay logic. The pixel clock comes from the board clocking block; no PLL lives inside this module.

## Interface
Parameters:
- H_SYNC, 3: hsync width, pixels
- H_BP, 40: horizontal back porch
- H_ACTIVE, 480: visible pixels per line
- H_FP, 2: horizontal front porch
- V_SYNC, 3; V_BP, 9; V_ACTIVE, 272; V_FP, 2: the same quantities in lines
- HS_POL, 0: active level of vga_hs
- VS_POL, 0: active level of vga_vs
- BOX_W, 150; BOX_H, 150: bouncing box size; elaboration error if BOX_W > H_ACTIVE or BOX_H > V_ACTIVE
- CHK_SHIFT, 4: checker square = 2^CHK_SHIFT pixels
- CNT_W, 13: counter and coordinate width; elaboration error if H_TOTAL or V_TOTAL ≥ 2^CNT_W

Ports:
- vga_clk, in, 1: pixel clock
- rst, in, 1: reset; synchronous, active-high
- en, in, 1: run enable
- mode, in, 2: 0 colour bars, 1 checkerboard, 2 box over bars, 3 solid
- solid_rgb, in, 24: mode-3 colour
- box_rgb, in, 24: box colour
- vga_hs, out, 1; vga_vs, out, 1: syncs
- vga_de, out, 1: active-video flag
- rgb, out, 24: pixel data
- pix_x, out, CNT_W; pix_y, out, CNT_W: active coordinates; 0 outside active region
- frame_start, out, 1: pulse on first cycle of frame
- line_start, out, 1: pulse on first cycle of line

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order: sync, back porch, active, front porch.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and wraps at V_TOTAL-1.
- Sync is active for h_cnt < H_SYNC and for whole lines v_cnt < V_SYNC; vs changes only at h_cnt = 0.
- Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), v_cnt likewise. x = h_cnt-(H_SYNC+H_BP), y similarly.
- en low: counters held at 0, and all outputs held at their reset values. On the first cycle en is high, frame 0 starts with h=v=0.
- mode and solid_rgb are sampled into shadow registers only on the frame's last cycle (h=H_TOTAL-1, v=V_TOTAL-1) and at reset (mode 0, solid 0). A mid-frame change never affects the current frame.
- Colour bars: 8 bars of BAR_W = H_ACTIVE/8 pixels, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. The bar index saturates at 7, so the last bar takes the remainder. Use a per-line bar counter; no divider.
- Checkerboard: FFFFFF when (x>>CHK_SHIFT)^(y>>CHK_SHIFT) has LSB 1, else 000000.
- Box: a pixel is inside when x in [bx, bx+BOX_W-1] and y in [by, by+BOX_H-1]. Inside pixels take box_rgb; all others use the bars pattern.
- Box motion runs every frame in all modes, stepping on the frame's last cycle. X_MAX = H_ACTIVE-BOX_W.
  - Direction dx=0: if bx==X_MAX then dx←1 and bx←bx-1, else bx←bx+1.
  - Direction dx=1: mirror of the above at 0.
  - If X_MAX = 0, bx stays 0. Y axis is identical.
  - Reset: bx=by=0, dx=dy=0.
- Outside the active region, rgb = 0.

## Timing
- All outputs are registered. Every output reflects the counter state of the previous cycle (1-cycle latency); hs, vs, de, rgb, pix_x, pix_y and strobes stay mutually aligned.
- Reset values: vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_de 0, rgb 0, pix_x/pix_y 0, frame_start 0, line_start 0. Internal counters and box state are at 0.
- rst has priority over en. Reset mid-frame aborts the frame, and the first valid output follows 1 cycle after rst and en allow counting.
- frame_start is high for exactly 1 cycle per frame, coincident with line_start.
- The frame-end cycle updates box position and mode shadow together. The new frame's first active pixel uses both new values.

## Structure
- Package vga_pattern_pkg holds: mode enum (MODE_BARS, MODE_CHECK, MODE_BOX, MODE_SOLID), the 8 bar colour constants, and a timing-total helper function.
- Sub-module vga_timing_core holds the counters, sync/de decode, x/y and strobes, exposed as pre-register signals. vga_pattern_gen adds the pattern, box and output registers.

## Test plan
Use a small geometry: H 2/3/16/1 (H_TOTAL 22), V 1/2/8/1 (V_TOTAL 12), BOX 4x3, CHK_SHIFT 2, HS_POL = VS_POL = 0.
- Reset then en=1 → frame_start at output cycle 1. hs low for 2 of every 22 cycles. vs low for the first 22 cycles. de high 16 cycles per line on 8 lines; 264-cycle frame.
- Mode 0 → each active line gives rgb FFFFFF ×2, FFFF00 ×2, … 000000 ×2; rgb = 0 in porches.
- Mode 1 → line y=0 gives 000000 ×4 then FFFFFF ×4 alternating. Line y=4 has inverted phase.
- Mode 2, box_rgb = FF00FF → frame 0 box at x 0..3, y 0..2. bx goes 0,1,…,12, then 11 at frame 13. by bounces at 5.
- Mode changed to 3 mid-frame with solid_rgb = 123456 → the current frame stays bars; the next frame is all 123456 in active region.
- rst asserted mid-line, then en toggled low for 5 cycles → outputs at reset values throughout. Restart gives frame_start 1 cycle after en rises.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA/LCD timing and test-pattern generator.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic int timing_total(input int sync_w, input int bp, input int active, input int fp);
    return sync_w + bp + active + fp;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Horizontal/vertical counters with combinational sync, data-enable, coordinate
// and strobe decode; the parent registers everything it takes from here.
module vga_timing_core
  import vga_pattern_pkg::*;
#(
  parameter int H_SYNC   = 3,
  parameter int H_BP     = 40,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 9,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 13
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             en,
  output logic             hs_o,
  output logic             vs_o,
  output logic             de_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             frame_start_o,
  output logic             line_start_o,
  output logic             frame_end_o
);

  localparam int H_TOTAL = timing_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = timing_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("vga_timing_core: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_act, v_act;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // vs is a whole-line decode of v_cnt, so it can only move when h wraps to 0
  assign h_act         = (h_q >= H_ACT_BEG) && (h_q < H_ACT_END);
  assign v_act         = (v_q >= V_ACT_BEG) && (v_q < V_ACT_END);
  assign de_o          = h_act && v_act;
  assign x_o           = de_o ? h_q - H_ACT_BEG : '0;
  assign y_o           = de_o ? v_q - V_ACT_BEG : '0;
  assign hs_o          = (h_q < H_SYNC_C) ? HS_POL : ~HS_POL;
  assign vs_o          = (v_q < V_SYNC_C) ? VS_POL : ~VS_POL;
  assign line_start_o  = (h_q == '0);
  assign frame_start_o = (h_q == '0) && (v_q == '0);
  assign frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: bars, checkerboard, bouncing box over bars and solid
// colour on top of vga_timing_core, with every output registered once.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_SYNC    = 3,
  parameter int H_BP      = 40,
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 9,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int BOX_W     = 150,
  parameter int BOX_H     = 150,
  parameter int CHK_SHIFT = 4,
  parameter int CNT_W     = 13
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_rgb,
  input  logic [23:0]      box_rgb,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [23:0]      rgb,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             line_start
);

  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_ACTIVE - BOX_W);
  localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_ACTIVE - BOX_H);
  localparam logic [CNT_W-1:0] BOX_W_M1 = CNT_W'(BOX_W - 1);
  localparam logic [CNT_W-1:0] BOX_H_M1 = CNT_W'(BOX_H - 1);

  if (BOX_W > H_ACTIVE || BOX_H > V_ACTIVE) begin : g_box_check
    $error("vga_pattern_gen: box larger than active area");
  end
  if (H_ACTIVE < 8 || CHK_SHIFT >= CNT_W) begin : g_geom_check
    $error("vga_pattern_gen: H_ACTIVE must be >= 8 and CHK_SHIFT < CNT_W");
  end

  logic             hs_c, vs_c, de_c, fs_c, ls_c, fe_c;
  logic [CNT_W-1:0] x_c, y_c;

  vga_timing_core #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W)
  ) u_timing (
    .vga_clk       (vga_clk),
    .rst           (rst),
    .en            (en),
    .hs_o          (hs_c),
    .vs_o          (vs_c),
    .de_o          (de_c),
    .x_o           (x_c),
    .y_o           (y_c),
    .frame_start_o (fs_c),
    .line_start_o  (ls_c),
    .frame_end_o   (fe_c)
  );

  // Returns {dir, pos} after one bounce step along an axis of travel [0, pmax].
  function automatic logic [CNT_W:0] axis_step(input logic [CNT_W-1:0] pos, input logic dir,
                                               input logic [CNT_W-1:0] pmax);
    if (pmax == '0)
      return '0;
    else if (!dir)
      return (pos == pmax) ? {1'b1, pos - 1'b1} : {1'b0, pos + 1'b1};
    else
      return (pos == '0) ? {1'b0, pos + 1'b1} : {1'b1, pos - 1'b1};
  endfunction

  mode_e            mode_q;
  logic [23:0]      solid_q;
  logic [CNT_W-1:0] bx_q, by_q;
  logic             dx_q, dy_q;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
    end else if (en && fe_c) begin
      mode_q       <= mode_e'(mode);
      solid_q      <= solid_rgb;
      {dx_q, bx_q} <= axis_step(bx_q, dx_q, X_MAX);
      {dy_q, by_q} <= axis_step(by_q, dy_q, Y_MAX);
    end
  end

  // Bar state tracks the pixel currently decoded; it restarts wherever de is low
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [CNT_W-1:0] bar_pos_q, bar_pos_d;

  always_comb begin
    bar_idx_d = '0;
    bar_pos_d = '0;
    if (de_c) begin
      bar_idx_d = bar_idx_q;
      bar_pos_d = bar_pos_q;
      if (bar_pos_q == BAR_LAST) begin
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
          bar_pos_d = '0;
        end
      end else begin
        bar_pos_d = bar_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst || !en) begin
      bar_idx_q <= '0;
      bar_pos_q <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_pos_q <= bar_pos_d;
    end
  end

  logic        in_box;
  logic [23:0] bars_rgb, rgb_d;

  assign bars_rgb = bar_colour(bar_idx_q);
  assign in_box   = (x_c >= bx_q) && (x_c <= bx_q + BOX_W_M1) &&
                    (y_c >= by_q) && (y_c <= by_q + BOX_H_M1);

  always_comb begin
    rgb_d = '0;
    if (de_c) begin
      unique case (mode_q)
        MODE_BARS:  rgb_d = bars_rgb;
        MODE_CHECK: rgb_d = (x_c[CHK_SHIFT] ^ y_c[CHK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
        MODE_BOX:   rgb_d = in_box ? box_rgb : bars_rgb;
        MODE_SOLID: rgb_d = solid_q;
      endcase
    end
  end

  logic             hs_q, vs_q, de_q, fs_q, ls_q;
  logic [23:0]      rgb_q;
  logic [CNT_W-1:0] x_q, y_q;

  always_ff @(posedge vga_clk) begin
    if (rst || !en) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      hs_q  <= hs_c;
      vs_q  <= vs_c;
      de_q  <= de_c;
      rgb_q <= rgb_d;
      x_q   <= x_c;
      y_q   <= y_c;
      fs_q  <= fs_c;
      ls_q  <= ls_c;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign rgb         = rgb_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen on a small panel geometry, checked every
// cycle against a frame/cycle-index reference model.
module tb_vga_pattern_gen;

  localparam int HS = 2, HB = 3, HA = 16, HF = 1;
  localparam int VS = 1, VB = 2, VA = 8, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 22
  localparam int VT = VS + VB + VA + VF;   // 12
  localparam int BW = 4, BH = 3, CS = 2, CW = 13;

  logic          vga_clk = 1'b0;
  logic          rst = 1'b1, en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [23:0]   solid_rgb = '0, box_rgb = 24'hFF00FF;
  logic          vga_hs, vga_vs, vga_de, frame_start, line_start;
  logic [23:0]   rgb;
  logic [CW-1:0] pix_x, pix_y;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .BOX_W(BW), .BOX_H(BH),
    .CHK_SHIFT(CS), .CNT_W(CW)
  ) dut (
    .vga_clk(vga_clk), .rst(rst), .en(en), .mode(mode),
    .solid_rgb(solid_rgb), .box_rgb(box_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: position in frame, completed frame count, sampled mode/solid
  int          t = 0, frame_n = 0, sh_mode = 0;
  logic [23:0] sh_solid = '0;
  logic        e_hs, e_vs, e_de, e_fs, e_ls;
  logic [23:0] e_rgb;
  int          e_x, e_y;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic int tri_pos(input int n, input int pmax);
    int p;
    if (pmax == 0) return 0;
    p = n % (2 * pmax);
    return (p <= pmax) ? p : 2 * pmax - p;
  endfunction

  task automatic model_edge();
    int h, v, x, y, bx, by, bar;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_ls = 1'b0;
    e_rgb = '0; e_x = 0; e_y = 0;
    if (rst) begin
      t = 0; frame_n = 0; sh_mode = 0; sh_solid = '0;
    end else if (!en) begin
      t = 0;
    end else begin
      h = t % HT;
      v = t / HT;
      e_hs = (h < HS) ? 1'b0 : 1'b1;
      e_vs = (v < VS) ? 1'b0 : 1'b1;
      e_ls = (h == 0);
      e_fs = (t == 0);
      e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      if (e_de) begin
        x = h - (HS + HB);
        y = v - (VS + VB);
        e_x = x; e_y = y;
        bar = (x / (HA / 8) > 7) ? 7 : x / (HA / 8);
        bx = tri_pos(frame_n, HA - BW);
        by = tri_pos(frame_n, VA - BH);
        case (sh_mode)
          0: e_rgb = bar_tab[bar];
          1: e_rgb = (((x >> CS) ^ (y >> CS)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
          2: e_rgb = (x >= bx && x < bx + BW && y >= by && y < by + BH) ? box_rgb : bar_tab[bar];
          default: e_rgb = sh_solid;
        endcase
      end
      if (t == HT * VT - 1) begin
        $display("frame %0d done: mode %0d box (%0d,%0d)", frame_n, sh_mode,
                 tri_pos(frame_n, HA - BW), tri_pos(frame_n, VA - BH));
        sh_mode  = int'(mode);
        sh_solid = solid_rgb;
        frame_n++;
        t = 0;
      end else begin
        t++;
      end
    end
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge vga_clk);
    model_edge();
    @(negedge vga_clk);
    check("hs", 32'(vga_hs), 32'(e_hs));
    check("vs", 32'(vga_vs), 32'(e_vs));
    check("de", 32'(vga_de), 32'(e_de));
    check("rgb", 32'(rgb), 32'(e_rgb));
    check("pix_x", 32'(pix_x), 32'(e_x));
    check("pix_y", 32'(pix_y), 32'(e_y));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("line_start", 32'(line_start), 32'(e_ls));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    mode = 2'd0; run(100);
    mode = 2'd1; run(HT * VT);
    mode = 2'd2; box_rgb = 24'hFF00FF; run(HT * VT * 15);
    mode = 2'd3; solid_rgb = 24'h123456; run(HT * VT * 2);
    run(7);
    repeat (2) step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    run(300);
    for (int i = 0; i < 5000; i++) begin
      int r;
      if ($urandom_range(0, 39) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        solid_rgb = 24'($urandom);
        box_rgb   = 24'($urandom);
      end
      r = int'($urandom_range(0, 999));
      step(r == 0, r >= 3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
